// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with receive FIFO; define UART_RX_MAJORITY_EN for 2-of-3 bit voting
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 19200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic [3:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic [8:0]                    rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int OSR_Q   = CLK_FREQ / (16 * BAUD_RATE);
  localparam int OSR_DIV = OSR_Q < 1 ? 1 : OSR_Q;
  localparam int DW      = OSR_DIV > 1 ? $clog2(OSR_DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic s1, rxs, tick, samp, bv, stop2, stop_n, perr, ferr, push, wr, pop, full;
  logic [DW-1:0] dcnt;
  logic [3:0] tcnt, bcnt, nb, nb_c;
  logic [1:0] par;
  logic [8:0] data;
  logic [10:0] pword, head;
  logic [10:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  // two-flop synchronizer, idles high so reset cannot look like a start bit
  always_ff @(posedge clk)
    if (rst) {s1, rxs} <= 2'b11;
    else {s1, rxs} <= {rx, s1};
  // oversample tick divider, 16 ticks per bit
  always_ff @(posedge clk)
    dcnt <= (rst || tick) ? '0 : dcnt + DW'(1);
  assign tick = dcnt == DW'(OSR_DIV - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] SAMP = 4'd9;
  logic m7, m8;
  // hold the tick-7 and tick-8 samples for the vote taken at tick 9
  always_ff @(posedge clk)
    if (rst) begin
      m7 <= 1'b1;
      m8 <= 1'b1;
    end else if (tick) begin
      if (tcnt == 4'd7) m7 <= rxs;
      if (tcnt == 4'd8) m8 <= rxs;
    end
  assign bv = (m7 & m8) | (m7 & rxs) | (m8 & rxs);
`else
  localparam logic [3:0] SAMP = 4'd8;
  assign bv = rxs;
`endif
  assign samp = tick && tcnt == SAMP;
  assign nb_c = cfg_data_bits < 4'd5 ? 4'd5 : cfg_data_bits > 4'd9 ? 4'd9 : cfg_data_bits;
  // frame FSM; the tick counter free-runs so each bit is sampled 16 ticks after the previous one
  always_ff @(posedge clk)
    if (rst) begin
      state  <= IDLE;
      tcnt   <= '0;
      bcnt   <= '0;
      nb     <= 4'd5;
      par    <= '0;
      stop2  <= 1'b0;
      stop_n <= 1'b0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
      data   <= '0;
      push   <= 1'b0;
      pword  <= '0;
    end else begin
      push <= 1'b0;
      if (tick) begin
        tcnt <= tcnt + 4'd1;
        case (state)
          IDLE: if (!rxs) begin
            state  <= START;
            tcnt   <= '0;
            bcnt   <= '0;
            nb     <= nb_c;
            par    <= cfg_parity;
            stop2  <= cfg_stop2;
            stop_n <= 1'b0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
            data   <= '0;
          end
          START: if (samp) state <= bv ? IDLE : DATA;
          DATA: if (samp) begin
            data[bcnt] <= bv;
            bcnt <= bcnt + 4'd1;
            if (bcnt == nb - 4'd1) state <= (par[0] ^ par[1]) ? PARITY : STOP;
          end
          PARITY: if (samp) begin
            perr  <= ^data ^ bv ^ par[0];
            state <= STOP;
          end
          STOP: if (samp) begin
            ferr <= ferr | ~bv;
            if (stop2 && !stop_n) stop_n <= 1'b1;
            else begin
              push  <= 1'b1;
              pword <= {ferr | ~bv, perr, data};
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  assign pop  = rx_valid && rx_ready;
  assign full = count == CW'(FIFO_DEPTH);
  assign wr   = push && (!full || pop);
  // FIFO storage, written only when the push is accepted
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= pword;
  // FIFO pointers, occupancy and overrun pulse
  always_ff @(posedge clk)
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      rx_overrun <= 1'b0;
    end else begin
      wptr       <= wptr + AW'(wr);
      rptr       <= rptr + AW'(pop);
      count      <= count + CW'(wr) - CW'(pop);
      rx_overrun <= push && full && !pop;
    end
  assign head          = mem[rptr];
  assign rx_valid      = count != '0;
  assign rx_data       = rx_valid ? head[8:0] : '0;
  assign rx_parity_err = rx_valid && head[9];
  assign rx_frame_err  = rx_valid && head[10];
  assign fifo_count    = count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and random frames checked against a queue model of the receive FIFO
module tb_uart_rx_fifo;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, cfg_stop2 = 1'b0, rx_ready = 1'b1;
  logic [3:0] cfg_data_bits = 4'd8;
  logic [1:0] cfg_parity = 2'd0;
  logic [8:0] rx_data;
  logic rx_parity_err, rx_frame_err, rx_valid, rx_overrun;
  logic [$clog2(DEPTH):0] fifo_count;
  int n_asrt = 0, n_fail = 0, ovr_seen = 0, ovr_exp = 0;
  logic [10:0] exp_q[$];

  uart_rx_fifo #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // consumer side: every accepted entry must be the oldest expected frame
  always @(negedge clk)
    if (!rst) begin
      if (rx_overrun) ovr_seen++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) chk("unexpected_entry", {21'd0, rx_frame_err, rx_parity_err, rx_data}, 32'hFFFF_FFFF);
        else chk("entry", {21'd0, rx_frame_err, rx_parity_err, rx_data}, {21'd0, exp_q.pop_front()});
      end
    end

  task automatic send_bit(input logic b, input logic g);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      rx = (g && c == 8) ? ~b : b;
    end
  endtask

  task automatic send_frame(input logic [8:0] d, input logic [3:0] cdb, input logic [1:0] cp,
                            input logic cs2, input logic flip_p, input logic bad1, input logic bad2,
                            input int gap, input logic glitch);
    int nb;
    logic [8:0] dm;
    logic pb, x, pe, fe;
    nb = cdb < 5 ? 5 : (cdb > 9 ? 9 : int'(cdb));
    dm = d & 9'((1 << nb) - 1);
    pb = ((cp == 2'd1) ? ~^dm : ^dm) ^ flip_p;
    x  = ^dm ^ pb;
    pe = (cp == 2'd1 && x == 1'b0) || (cp == 2'd2 && x == 1'b1);
    fe = bad1 || (cs2 && bad2);
    cfg_data_bits = cdb;
    cfg_parity = cp;
    cfg_stop2 = cs2;
    if (exp_q.size() >= DEPTH) ovr_exp++;
    else exp_q.push_back({fe, pe, dm});
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nb; i++) send_bit(dm[i], glitch && i == 2);
    if (cp == 2'd1 || cp == 2'd2) send_bit(pb, 1'b0);
    send_bit(~bad1, 1'b0);
    if (cs2) send_bit(~bad2, 1'b0);
    @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_valid", rx_valid, 0);
    chk("idle_count", fifo_count, 0);

    send_frame(9'h0A5, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 20, 1'b0);
    wait_drain("drain_8n1");
    send_frame(9'h1FF, 4'd9, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 20, 1'b0);
    wait_drain("drain_9e_perr");
    send_frame(9'h05A, 4'd8, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 20, 1'b0);
    wait_drain("drain_8o1");
    send_frame(9'h0C3, 4'd8, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 20, 1'b0);
    send_frame(9'h03C, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 20, 1'b0);
    wait_drain("drain_8n2_ferr");
    send_frame(9'h1AB, 4'd2, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 20, 1'b0);
    send_frame(9'h1AB, 4'd15, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 20, 1'b0);
    wait_drain("drain_clamp");

    rx_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_frame(9'(8'h30 + i * 7), 4'd8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    repeat (20) @(negedge clk);
    chk("full_count", fifo_count, DEPTH);
    chk("overrun_pulses", ovr_seen, ovr_exp);
    chk("overrun_once", ovr_exp, 1);
    rx_ready = 1'b1;
    wait_drain("drain_full");
    chk("empty_count", fifo_count, 0);

    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_count", fifo_count, 0);
    chk("glitch_valid", rx_valid, 0);
    send_frame(9'h066, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 20, 1'b0);
    wait_drain("drain_after_glitch");
`ifdef UART_RX_MAJORITY_EN
    send_frame(9'h0F4, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 20, 1'b1);
    wait_drain("drain_majority");
`endif

    cfg_data_bits = 4'd8;
    cfg_parity = 2'd0;
    cfg_stop2 = 1'b0;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_valid", rx_valid, 0);
    rst = 1'b0;
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_overrun", ovr_seen, ovr_exp);
    send_frame(9'h055, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 20, 1'b0);
    wait_drain("drain_after_rst");

    for (int i = 0; i < 24; i++) begin
      send_frame(9'($urandom), 4'($urandom_range(3, 12)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, 20, 1'b0);
      wait_drain("drain_random");
    end
    chk("final_overrun", ovr_seen, ovr_exp);
    chk("final_count", fifo_count, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
